spmv_vec_prefetch_ctrl: RTL and testbench

SPMV_VEC_PREFETCH_CTRL -- requirements
Module: spmv_vec_prefetch_ctrl

---
 rtl/spmv_vec_prefetch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_spmv_vec_prefetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_vec_prefetch_ctrl.sv
// spmv_vec_prefetch_ctrl
//   Takes INIT / LD_SPM / LD_VEC commands that describe a sparse matrix and a
//   dense vector. It derives the matrix array pointers, then prefetches the
//   vector into a line buffer. Up to MAX_OUT line requests can be in flight,
//   and their responses may return out of order. When every line is
//   resident, it pulses spmv_start and returns a status response to the core.
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_val/busy/cmd_opcode/...   command handshake (busy = !cmd_rdy)
//   resp_val/resp_rdy/resp_data   completion {status[63:62], lines[15:0]}
//   mem_req_*                     line read requests (transid = line index)
//   mem_resp_*                    line read responses
//   vbuf_wr_*                     vector buffer line write
//   spm_*, vec_len                latched configuration
//   spmv_start                    one-cycle pulse when the vector is loaded
module spmv_vec_prefetch_ctrl #(
   parameter int ADDR_W     = 40,
   parameter int LINE_BYTES = 64,
   parameter int ELEM_BYTES = 4,
   parameter int MAX_OUT    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_val,
   output logic                    busy,
   input  logic [5:0]              cmd_opcode,
   input  logic [63:0]             cmd_config_data,
   output logic                    resp_val,
   input  logic                    resp_rdy,
   output logic [63:0]             resp_data,
   output logic                    mem_req_val,
   input  logic                    mem_req_rdy,
   output logic [5:0]              mem_req_transid,
   output logic [ADDR_W-1:0]       mem_req_addr,
   input  logic                    mem_resp_val,
   input  logic [5:0]              mem_resp_transid,
   input  logic [LINE_BYTES*8-1:0] mem_resp_data,
   output logic                    vbuf_wr_en,
   output logic [5:0]              vbuf_wr_line,
   output logic [LINE_BYTES*8-1:0] vbuf_wr_data,
   output logic [ADDR_W-1:0]       spm_val_ptr,
   output logic [ADDR_W-1:0]       spm_col_ptr,
   output logic [ADDR_W-1:0]       spm_row_ptr,
   output logic [15:0]             spm_nnz,
   output logic [15:0]             spm_nnzr,
   output logic [15:0]             vec_len,
   output logic                    spmv_start
);
   localparam int LB_LG = $clog2(LINE_BYTES);
   localparam int EB_LG = $clog2(ELEM_BYTES);
   // vec_len*ELEM_BYTES plus one spare bit for the round-up add
   localparam int LW    = 16 + EB_LG + 1;

   localparam logic [5:0] OP_INIT   = 6'd0;
   localparam logic [5:0] OP_LD_SPM = 6'd1;
   localparam logic [5:0] OP_LD_VEC = 6'd2;

   typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_PREFETCH, S_RESP} state_t;

   state_t            state, state_nxt;
   logic              have_spm, have_vec;
   logic [ADDR_W-1:0] vec_ptr;
   logic [LW-1:0]     lines;
   logic [6:0]        issued, received, outstanding;
   logic [63:0]       pending;
   logic [1:0]        status;

   logic              cmd_fire, illegal, cfg_done, lines_ok, req_fire, rsp_acc, done;
   logic [LW-1:0]     bytes_w, lines_calc;
   logic [ADDR_W-1:0] nnz_off;
   logic [63:0]       pend_set, pend_clr;
   logic              unused_cfg;

   assign unused_cfg = ^cmd_config_data;

   assign cfg_done   = (state == S_CONFIG) && have_spm && have_vec;
   // Also block commands in the single cycle that launches the prefetch,
   // so that no configuration can change under the line count computation.
   assign busy       = (state == S_PREFETCH) || (state == S_RESP) || cfg_done;
   assign cmd_fire   = cmd_val && !busy;
   assign illegal    = cmd_opcode > OP_LD_VEC;

   assign bytes_w    = LW'(vec_len) << EB_LG;
   assign lines_calc = (bytes_w + LW'(LINE_BYTES - 1)) >> LB_LG;
   assign lines_ok   = (lines != '0) && (lines <= LW'(64));
   assign nnz_off    = ADDR_W'(cmd_config_data[15:0]) << EB_LG;

   assign mem_req_val     = (state == S_PREFETCH) && lines_ok &&
                            (LW'(issued) < lines) && (outstanding < 7'(MAX_OUT));
   assign mem_req_transid = issued[5:0];
   assign mem_req_addr    = vec_ptr + (ADDR_W'(issued) << LB_LG);
   assign req_fire        = mem_req_val && mem_req_rdy;

   // Only tags with a live request are accepted; stale or duplicate
   // responses fall through with no effect.
   assign rsp_acc      = (state == S_PREFETCH) && mem_resp_val && pending[mem_resp_transid];
   assign vbuf_wr_en   = rsp_acc;
   assign vbuf_wr_line = mem_resp_transid;
   assign vbuf_wr_data = mem_resp_data;

   assign done     = (state == S_PREFETCH) && lines_ok && (LW'(received) == lines);
   assign pend_set = req_fire ? (64'd1 << issued[5:0]) : 64'd0;
   assign pend_clr = rsp_acc  ? (64'd1 << mem_resp_transid) : 64'd0;

   assign resp_val  = (state == S_RESP);
   assign resp_data = {status, 46'd0, 9'd0, received};

   always_comb begin
      state_nxt  = state;
      spmv_start = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_fire) begin
               if (illegal)                    state_nxt = S_RESP;
               else if (cmd_opcode == OP_INIT) state_nxt = S_CONFIG;
            end
         end
         S_CONFIG: begin
            if (cfg_done)                  state_nxt = S_PREFETCH;
            else if (cmd_fire && illegal)  state_nxt = S_RESP;
         end
         S_PREFETCH: begin
            if (!lines_ok) state_nxt = S_RESP;
            else if (done) begin
               state_nxt  = S_RESP;
               spmv_start = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_rdy) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         have_spm    <= 1'b0;
         have_vec    <= 1'b0;
         vec_ptr     <= '0;
         spm_val_ptr <= '0;
         spm_col_ptr <= '0;
         spm_row_ptr <= '0;
         spm_nnz     <= '0;
         spm_nnzr    <= '0;
         vec_len     <= '0;
         lines       <= '0;
         issued      <= '0;
         received    <= '0;
         outstanding <= '0;
         pending     <= '0;
         status      <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_fire) begin
            if (illegal) status <= 2'd2;
            else if (cmd_opcode == OP_INIT) begin
               spm_val_ptr <= cmd_config_data[ADDR_W-1:0];
               have_spm    <= 1'b0;
               have_vec    <= 1'b0;
            end else if (state == S_CONFIG && cmd_opcode == OP_LD_SPM) begin
               spm_nnz     <= cmd_config_data[15:0];
               spm_nnzr    <= cmd_config_data[31:16];
               spm_col_ptr <= spm_val_ptr + nnz_off;
               spm_row_ptr <= spm_val_ptr + nnz_off + nnz_off;
               have_spm    <= 1'b1;
            end else if (state == S_CONFIG && cmd_opcode == OP_LD_VEC) begin
               vec_ptr  <= cmd_config_data[ADDR_W-1:0] & ~ADDR_W'(LINE_BYTES - 1);
               vec_len  <= cmd_config_data[63:48];
               have_vec <= 1'b1;
            end
         end
         if (cfg_done) begin
            lines       <= lines_calc;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            pending     <= '0;
         end else if (state == S_PREFETCH) begin
            issued      <= issued + 7'(req_fire);
            received    <= received + 7'(rsp_acc);
            outstanding <= outstanding + 7'(req_fire) - 7'(rsp_acc);
            pending     <= (pending | pend_set) & ~pend_clr;
            if (!lines_ok)  status <= (lines == '0) ? 2'd0 : 2'd1;
            else if (done)  status <= 2'd0;
         end else if (state == S_RESP && resp_rdy) begin
            issued   <= '0;
            received <= '0;
         end
      end
   end
endmodule

// File: tb/tb_spmv_vec_prefetch_ctrl.sv
// Directed bench for spmv_vec_prefetch_ctrl (default parameters).
module tb_spmv_vec_prefetch_ctrl;
   localparam int AW = 40;
   localparam int DW = 512;

   logic          clk, rst_n;
   logic          cmd_val, busy, resp_val, resp_rdy;
   logic [5:0]    cmd_opcode;
   logic [63:0]   cmd_config_data, resp_data;
   logic          mem_req_val, mem_req_rdy, mem_resp_val;
   logic [5:0]    mem_req_transid, mem_resp_transid;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_resp_data, vbuf_wr_data;
   logic          vbuf_wr_en, spmv_start;
   logic [5:0]    vbuf_wr_line;
   logic [AW-1:0] spm_val_ptr, spm_col_ptr, spm_row_ptr;
   logic [15:0]   spm_nnz, spm_nnzr, vec_len;

   int checks = 0;
   int failures = 0;

   spmv_vec_prefetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .busy(busy),
      .cmd_opcode(cmd_opcode), .cmd_config_data(cmd_config_data),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
      .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
      .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
      .mem_resp_data(mem_resp_data), .vbuf_wr_en(vbuf_wr_en),
      .vbuf_wr_line(vbuf_wr_line), .vbuf_wr_data(vbuf_wr_data),
      .spm_val_ptr(spm_val_ptr), .spm_col_ptr(spm_col_ptr), .spm_row_ptr(spm_row_ptr),
      .spm_nnz(spm_nnz), .spm_nnzr(spm_nnzr), .vec_len(vec_len), .spmv_start(spmv_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ld_vec(input logic [15:0] len, input logic [39:0] ptr);
      return {len, 8'h00, ptr};
   endfunction

   task automatic send_cmd(input logic [5:0] op, input logic [63:0] d);
      int n;
      @(negedge clk);
      cmd_val = 1'b1; cmd_opcode = op; cmd_config_data = d;
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      if (busy) begin
         checks++; failures++;
         $display("FAIL cmd_accept_timeout op=%0d busy=%b exp=0", op, busy);
      end
      @(posedge clk); #1;
      cmd_val = 1'b0;
   endtask

   task automatic wait_resp(input string name);
      int n;
      n = 0;
      while (!resp_val && n < 40) begin @(negedge clk); n++; end
      if (!resp_val) begin
         checks++; failures++;
         $display("FAIL %s_resp_timeout resp_val=%b exp=1", name, resp_val);
      end
   endtask

   task automatic ack_resp();
      @(negedge clk); resp_rdy = 1'b1;
      @(posedge clk); #1; resp_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_val = 1'b0; cmd_opcode = '0; cmd_config_data = '0;
      resp_rdy = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
      mem_resp_transid = '0; mem_resp_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_val !== 1'b0) begin failures++; $display("FAIL reset_resp_val got=%b exp=0", resp_val); end
      checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL reset_mem_req_val got=%b exp=0", mem_req_val); end
      checks++; if ({vbuf_wr_en, spmv_start} !== 2'b00) begin failures++; $display("FAIL reset_wr_start got=%b exp=00", {vbuf_wr_en, spmv_start}); end
      checks++; if ({spm_val_ptr, spm_col_ptr, vec_len} !== '0) begin failures++; $display("FAIL reset_cfg got=%h/%h/%h exp=0", spm_val_ptr, spm_col_ptr, vec_len); end
   endtask

   // INIT 0x1000, nnz=16, vec 0x2013 (aligned to 0x2000) len=32 -> 2 lines,
   // responses returned t1 then t0.
   task automatic test_basic();
      int n;
      logic [AW-1:0] addr[2];
      logic [5:0]    tid[2];
      logic [DW-1:0] d1, d0;
      d1 = {16{32'hA5A5_0001}};
      d0 = {16{32'h5A5A_0000}};
      send_cmd(6'd0, 64'h1000);
      send_cmd(6'd1, {32'd0, 16'd3, 16'd16});
      checks++; if (spm_col_ptr !== 40'h1040) begin failures++; $display("FAIL basic_col_ptr got=%h exp=1040", spm_col_ptr); end
      checks++; if (spm_row_ptr !== 40'h1080) begin failures++; $display("FAIL basic_row_ptr got=%h exp=1080", spm_row_ptr); end
      checks++; if ({spm_nnz, spm_nnzr} !== {16'd16, 16'd3}) begin failures++; $display("FAIL basic_nnz got=%0d/%0d exp=16/3", spm_nnz, spm_nnzr); end
      mem_req_rdy = 1'b1;
      send_cmd(6'd2, ld_vec(16'd32, 40'h2013));
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_req_val) begin
            if (n < 2) begin addr[n] = mem_req_addr; tid[n] = mem_req_transid; end
            n++;
         end
      end
      mem_req_rdy = 1'b0;
      checks++; if (n != 2) begin failures++; $display("FAIL basic_req_count got=%0d exp=2", n); end
      checks++; if (n >= 2 && {addr[0], tid[0], addr[1], tid[1]} !== {40'h2000, 6'd0, 40'h2040, 6'd1}) begin
         failures++; $display("FAIL basic_req_addr got=%h/%0d %h/%0d exp=2000/0 2040/1", addr[0], tid[0], addr[1], tid[1]);
      end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_prefetch got=%b exp=1", busy); end
      mem_resp_val = 1'b1; mem_resp_transid = 6'd1; mem_resp_data = d1; #1;
      checks++; if ({vbuf_wr_en, vbuf_wr_line} !== {1'b1, 6'd1} || vbuf_wr_data !== d1) begin
         failures++; $display("FAIL ooo_wr_t1 got=%b/%0d exp=1/1", vbuf_wr_en, vbuf_wr_line);
      end
      checks++; if (spmv_start !== 1'b0) begin failures++; $display("FAIL ooo_early_start got=%b exp=0", spmv_start); end
      @(posedge clk); #1; mem_resp_val = 1'b0;
      @(negedge clk);
      mem_resp_val = 1'b1; mem_resp_transid = 6'd0; mem_resp_data = d0; #1;
      checks++; if ({vbuf_wr_en, vbuf_wr_line} !== {1'b1, 6'd0} || vbuf_wr_data !== d0) begin
         failures++; $display("FAIL ooo_wr_t0 got=%b/%0d exp=1/0", vbuf_wr_en, vbuf_wr_line);
      end
      @(posedge clk); #1; mem_resp_val = 1'b0;
      checks++; if ({spmv_start, resp_val} !== 2'b10) begin failures++; $display("FAIL basic_start got=%b exp=10", {spmv_start, resp_val}); end
      @(posedge clk); #1;
      checks++; if ({spmv_start, resp_val} !== 2'b01) begin failures++; $display("FAIL basic_start_pulse got=%b exp=01", {spmv_start, resp_val}); end
      checks++; if (resp_data !== 64'h2) begin failures++; $display("FAIL basic_resp_data got=%h exp=2", resp_data); end
   endtask

   task automatic test_resp_hold();
      repeat (5) begin
         @(negedge clk);
         checks++; if ({resp_val, busy} !== 2'b11 || resp_data !== 64'h2) begin
            failures++; $display("FAIL hold_resp got=%b/%b/%h exp=1/1/2", resp_val, busy, resp_data);
         end
      end
      ack_resp();
      checks++; if ({resp_val, busy} !== 2'b00) begin failures++; $display("FAIL hold_release got=%b exp=00", {resp_val, busy}); end
      checks++; if (spm_col_ptr !== 40'h1040) begin failures++; $display("FAIL hold_retain_cfg got=%h exp=1040", spm_col_ptr); end
   endtask

   // 64 lines, no responses: issue stops at MAX_OUT=8 and resumes after one.
   task automatic test_max_out();
      int n;
      send_cmd(6'd0, 64'h0);
      send_cmd(6'd1, 64'd0);
      send_cmd(6'd2, ld_vec(16'd1024, 40'h40000));
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         checks++; if ({mem_req_val, mem_req_addr, mem_req_transid} !== {1'b1, 40'h40000, 6'd0}) begin
            failures++; $display("FAIL stall_hold got=%b/%h/%0d exp=1/40000/0", mem_req_val, mem_req_addr, mem_req_transid);
         end
      end
      mem_req_rdy = 1'b1;
      n = 0;
      repeat (20) begin
         if (mem_req_val) n++;
         @(negedge clk);
      end
      checks++; if (n != 8) begin failures++; $display("FAIL maxout_count got=%0d exp=8", n); end
      checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL maxout_val got=%b exp=0", mem_req_val); end
      mem_resp_val = 1'b1; mem_resp_transid = 6'd3; mem_resp_data = '1; #1;
      checks++; if ({vbuf_wr_en, vbuf_wr_line} !== {1'b1, 6'd3}) begin failures++; $display("FAIL maxout_wr got=%b/%0d exp=1/3", vbuf_wr_en, vbuf_wr_line); end
      @(posedge clk); #1; mem_resp_val = 1'b0;
      checks++; if ({mem_req_val, mem_req_addr, mem_req_transid} !== {1'b1, 40'h40200, 6'd8}) begin
         failures++; $display("FAIL maxout_resume got=%b/%h/%0d exp=1/40200/8", mem_req_val, mem_req_addr, mem_req_transid);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); rst_n = 1'b0; mem_req_rdy = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      checks++; if ({busy, mem_req_val, vec_len} !== {2'b00, 16'd0}) begin
         failures++; $display("FAIL rstmid_state got=%b/%b/%0d exp=0/0/0", busy, mem_req_val, vec_len);
      end
      @(negedge clk);
      mem_resp_val = 1'b1; mem_resp_transid = 6'd0; #1;
      checks++; if (vbuf_wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_stale_wr got=%b exp=0", vbuf_wr_en); end
      @(posedge clk); #1; mem_resp_val = 1'b0;
      checks++; if ({busy, resp_val} !== 2'b00) begin failures++; $display("FAIL rstmid_idle got=%b exp=00", {busy, resp_val}); end
   endtask

   task automatic test_lines_edge();
      int n;
      logic seen;
      send_cmd(6'd0, 64'h500);
      send_cmd(6'd1, 64'd1);
      send_cmd(6'd2, ld_vec(16'd0, 40'h8000));
      n = 0; seen = 1'b0;
      while (!resp_val && n < 20) begin
         @(negedge clk);
         if (mem_req_val) seen = 1'b1;
         n++;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL len0_req got=%b exp=0", seen); end
      checks++; if ({resp_val, resp_data} !== {1'b1, 64'h0}) begin failures++; $display("FAIL len0_resp got=%b/%h exp=1/0", resp_val, resp_data); end
      ack_resp();
      send_cmd(6'd0, 64'h500);
      send_cmd(6'd1, 64'd1);
      send_cmd(6'd2, ld_vec(16'd2000, 40'h8000));
      wait_resp("len2000");
      checks++; if (resp_data !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL len2000_resp got=%h exp=4000000000000000", resp_data); end
      ack_resp();
      send_cmd(6'd1, 64'd99);
      checks++; if ({spm_nnz, busy} !== {16'd1, 1'b0}) begin failures++; $display("FAIL idle_ld_ignored got=%0d/%b exp=1/0", spm_nnz, busy); end
      send_cmd(6'd7, 64'hFFFF);
      wait_resp("illegal");
      checks++; if (resp_data !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL illegal_resp got=%h exp=8000000000000000", resp_data); end
      checks++; if ({spm_val_ptr, vec_len} !== {40'h500, 16'd2000}) begin failures++; $display("FAIL illegal_keep_cfg got=%h/%0d exp=500/2000", spm_val_ptr, vec_len); end
      ack_resp();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal_return got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resp_hold();
      test_max_out();
      test_reset_mid();
      test_lines_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
